axi4_lite_ctrl_arbiter: RTL and testbench

//   Shares the ctrl_* port of the AXI4-Lite master among NUM_REQ requesters.

---
 rtl/axi4_lite_ctrl_arbiter_pkg.sv | 15 +
 rtl/axi4_lite_ctrl_arbiter_if.sv | 55 +++++
 rtl/axi4_lite_rr_arbiter.sv | 57 +++++
 rtl/axi4_lite_ctrl_arbiter.sv | 166 ++++++++++++++++
 tb/tb_axi4_lite_ctrl_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_ctrl_arbiter_pkg.sv
// rtl/axi4_lite_ctrl_arbiter_pkg.sv - channel FSM states and AXI response codes for the ctrl arbiter
package axi4_lite_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_ctrl_arbiter_if.sv
// rtl/axi4_lite_ctrl_arbiter_if.sv - requester-side and master-side bundles of the ctrl arbiter
interface axi4_lite_arb_req_if #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic [NUM_REQ-1:0]                 wr_req;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0]   wr_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]      wr_data;
    logic [NUM_REQ*DATA_WIDTH/8-1:0]    wr_strb;
    logic [NUM_REQ-1:0]                 wr_gnt;
    logic [NUM_REQ-1:0]                 wr_done;
    logic [1:0]                         wr_bresp;
    logic [NUM_REQ-1:0]                 rd_req;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0]   rd_addr;
    logic [NUM_REQ-1:0]                 rd_gnt;
    logic [NUM_REQ-1:0]                 rd_done;
    logic [DATA_WIDTH-1:0]              rd_data;
    logic [1:0]                         rd_rresp;

    modport master (
        output wr_req, wr_addr, wr_data, wr_strb, rd_req, rd_addr,
        input  wr_gnt, wr_done, wr_bresp, rd_gnt, rd_done, rd_data, rd_rresp
    );
    modport slave (
        input  wr_req, wr_addr, wr_data, wr_strb, rd_req, rd_addr,
        output wr_gnt, wr_done, wr_bresp, rd_gnt, rd_done, rd_data, rd_rresp
    );
endinterface

interface axi4_lite_arb_ctrl_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic [ADDRESS_WIDTH-1:0]   m_waddr;
    logic [DATA_WIDTH-1:0]      m_wdata;
    logic [DATA_WIDTH/8-1:0]    m_wstrb;
    logic [ADDRESS_WIDTH-1:0]   m_raddr;
    logic                       m_write_req;
    logic                       m_read_req;
    logic                       m_write_done;
    logic                       m_read_done;
    logic [1:0]                 m_bresp;
    logic [1:0]                 m_rresp;
    logic [DATA_WIDTH-1:0]      m_rdata;

    modport master (
        output m_waddr, m_wdata, m_wstrb, m_raddr, m_write_req, m_read_req,
        input  m_write_done, m_read_done, m_bresp, m_rresp, m_rdata
    );
    modport slave (
        input  m_waddr, m_wdata, m_wstrb, m_raddr, m_write_req, m_read_req,
        output m_write_done, m_read_done, m_bresp, m_rresp, m_rdata
    );
endinterface

// File: rtl/axi4_lite_rr_arbiter.sv
// rtl/axi4_lite_rr_arbiter.sv - one-hot round-robin grant with owned pointer; ARB_FIXED_PRIO_EN selects fixed priority
module axi4_lite_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] id
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] lo_id;

    always_comb begin
        lo_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) lo_id = ID_W'(i);
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    logic unused_ctl;
    assign unused_ctl = ^{clk, resetn, advance};
    assign id = lo_id;
`else
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] hi_id;
    logic            hi_hit;

    // Lowest request at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_id  = '0;
        hi_hit = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (ID_W'(i) >= ptr)) begin
                hi_id  = ID_W'(i);
                hi_hit = 1'b1;
            end
        end
    end

    assign id = hi_hit ? hi_id : lo_id;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(id) == NUM_REQ - 1) ? '0 : id + ID_W'(1);
        end
    end
`endif

    assign gnt = (|req) ? (NUM_REQ'(1) << id) : '0;

endmodule

// File: rtl/axi4_lite_ctrl_arbiter.sv
// rtl/axi4_lite_ctrl_arbiter.sv - shares the AXI4-Lite master ctrl port among requesters; ARB_FIXED_PRIO_EN via arbiter
module axi4_lite_ctrl_arbiter
    import axi4_lite_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int STARTUP_CYCLES = 3
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    axi4_lite_arb_req_if.slave   req_bus,
    axi4_lite_arb_ctrl_if.master ctrl_bus
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SU_W   = $clog2(STARTUP_CYCLES + 2);

    logic [SU_W-1:0] startup_cnt;
    logic            startup_done;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            startup_cnt <= SU_W'(STARTUP_CYCLES);
        end else if (startup_cnt != '0) begin
            startup_cnt <= startup_cnt - SU_W'(1);
        end
    end

    assign startup_done = (startup_cnt == '0);

    arb_state_e             wr_state, wr_state_nxt, rd_state, rd_state_nxt;
    logic                   wr_open, rd_open, wr_issue, rd_issue;
    logic [NUM_REQ-1:0]     wr_gnt_i, rd_gnt_i;
    logic [ID_W-1:0]        wr_win, rd_win, wr_id, rd_id;
    logic [ADDRESS_WIDTH-1:0] wr_addr_sel, rd_addr_sel;
    logic [DATA_WIDTH-1:0]  wr_data_sel;
    logic [STRB_W-1:0]      wr_strb_sel;

    // Grants only exist in ARB_IDLE once the master has come out of reset.
    assign wr_open = (wr_state == ARB_IDLE) && startup_done;
    assign rd_open = (rd_state == ARB_IDLE) && startup_done;

    axi4_lite_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clk     (ACLK),
        .resetn  (ARESETn),
        .req     (req_bus.wr_req & {NUM_REQ{wr_open}}),
        .advance (|wr_gnt_i),
        .gnt     (wr_gnt_i),
        .id      (wr_win)
    );

    axi4_lite_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clk     (ACLK),
        .resetn  (ARESETn),
        .req     (req_bus.rd_req & {NUM_REQ{rd_open}}),
        .advance (|rd_gnt_i),
        .gnt     (rd_gnt_i),
        .id      (rd_win)
    );

    assign req_bus.wr_gnt       = wr_gnt_i;
    assign req_bus.rd_gnt       = rd_gnt_i;
    assign ctrl_bus.m_write_req = wr_issue;
    assign ctrl_bus.m_read_req  = rd_issue;

    always_comb begin
        wr_addr_sel = '0;
        wr_data_sel = '0;
        wr_strb_sel = '0;
        rd_addr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt_i[i]) begin
                wr_addr_sel = req_bus.wr_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                wr_data_sel = req_bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                wr_strb_sel = req_bus.wr_strb[i*STRB_W +: STRB_W];
            end
            if (rd_gnt_i[i]) begin
                rd_addr_sel = req_bus.rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_state <= ARB_IDLE;
            rd_state <= ARB_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        wr_issue     = 1'b0;
        case (wr_state)
            ARB_IDLE:  if (|wr_gnt_i) wr_state_nxt = ARB_ISSUE;
            ARB_ISSUE: begin
                wr_issue     = 1'b1;
                wr_state_nxt = ARB_WAIT;
            end
            ARB_WAIT:  if (ctrl_bus.m_write_done) wr_state_nxt = ARB_IDLE;
            default:   wr_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        rd_state_nxt = rd_state;
        rd_issue     = 1'b0;
        case (rd_state)
            ARB_IDLE:  if (|rd_gnt_i) rd_state_nxt = ARB_ISSUE;
            ARB_ISSUE: begin
                rd_issue     = 1'b1;
                rd_state_nxt = ARB_WAIT;
            end
            ARB_WAIT:  if (ctrl_bus.m_read_done) rd_state_nxt = ARB_IDLE;
            default:   rd_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_id            <= '0;
            ctrl_bus.m_waddr <= '0;
            ctrl_bus.m_wdata <= '0;
            ctrl_bus.m_wstrb <= '0;
            req_bus.wr_done  <= '0;
            req_bus.wr_bresp <= '0;
        end else begin
            req_bus.wr_done <= '0;
            if (|wr_gnt_i) begin
                wr_id            <= wr_win;
                ctrl_bus.m_waddr <= wr_addr_sel;
                ctrl_bus.m_wdata <= wr_data_sel;
                ctrl_bus.m_wstrb <= wr_strb_sel;
            end
            if ((wr_state == ARB_WAIT) && ctrl_bus.m_write_done) begin
                req_bus.wr_done  <= NUM_REQ'(1) << wr_id;
                req_bus.wr_bresp <= ctrl_bus.m_bresp;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rd_id            <= '0;
            ctrl_bus.m_raddr <= '0;
            req_bus.rd_done  <= '0;
            req_bus.rd_data  <= '0;
            req_bus.rd_rresp <= '0;
        end else begin
            req_bus.rd_done <= '0;
            if (|rd_gnt_i) begin
                rd_id            <= rd_win;
                ctrl_bus.m_raddr <= rd_addr_sel;
            end
            if ((rd_state == ARB_WAIT) && ctrl_bus.m_read_done) begin
                req_bus.rd_done  <= NUM_REQ'(1) << rd_id;
                req_bus.rd_data  <= ctrl_bus.m_rdata;
                req_bus.rd_rresp <= ctrl_bus.m_rresp;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_ctrl_arbiter.sv
// tb/tb_axi4_lite_ctrl_arbiter.sv - directed scoreboard bench for axi4_lite_ctrl_arbiter
module tb_axi4_lite_ctrl_arbiter;
    import axi4_lite_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axi4_lite_arb_req_if  #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) rb ();
    axi4_lite_arb_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW))              cb ();

    axi4_lite_ctrl_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARTUP_CYCLES(3)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .req_bus  (rb.slave),
        .ctrl_bus (cb.master)
    );

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t wr_sb[$];
    exp_t rd_sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input int i, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        rb.wr_addr[i*AW +: AW] = addr;
        rb.wr_data[i*DW +: DW] = data;
        rb.wr_strb[i*SW +: SW] = strb;
    endtask

    task automatic wr_expect_grant(input string tag, input int id, input logic [1:0] resp);
        chk({tag, "_wgnt"}, 64'(rb.wr_gnt), 64'(1) << id);
        wr_sb.push_back('{id: id, addr: rb.wr_addr[id*AW +: AW], resp: resp, data: 32'h0});
    endtask

    task automatic rd_expect_grant(input string tag, input int id, input logic [1:0] resp, input logic [31:0] data);
        chk({tag, "_rgnt"}, 64'(rb.rd_gnt), 64'(1) << id);
        rd_sb.push_back('{id: id, addr: rb.rd_addr[id*AW +: AW], resp: resp, data: data});
    endtask

    task automatic wait_wr_done(input string tag);
        int   n = 0;
        exp_t e;
        while (rb.wr_done == '0 && n < 8) begin
            @(negedge ACLK);
            n++;
        end
        if (wr_sb.size() == 0) begin
            chk({tag, "_wsb_empty"}, 64'(rb.wr_done), 64'h0);
            return;
        end
        e = wr_sb.pop_front();
        chk({tag, "_wdone"}, 64'(rb.wr_done), 64'(1) << e.id);
        chk({tag, "_bresp"}, 64'(rb.wr_bresp), 64'(e.resp));
    endtask

    task automatic wait_rd_done(input string tag);
        int   n = 0;
        exp_t e;
        while (rb.rd_done == '0 && n < 8) begin
            @(negedge ACLK);
            n++;
        end
        if (rd_sb.size() == 0) begin
            chk({tag, "_rsb_empty"}, 64'(rb.rd_done), 64'h0);
            return;
        end
        e = rd_sb.pop_front();
        chk({tag, "_rdone"}, 64'(rb.rd_done), 64'(1) << e.id);
        chk({tag, "_rdata"}, 64'(rb.rd_data), 64'(e.data));
        chk({tag, "_rresp"}, 64'(rb.rd_rresp), 64'(e.resp));
    endtask

    // Called at the grant cycle; ends at the negedge where wr_done is visible.
    task automatic wr_complete(input string tag, input bit drop);
        exp_t e;
        e = wr_sb[0];
        @(negedge ACLK);
        if (drop) rb.wr_req = '0;
        chk({tag, "_mwreq"}, 64'(cb.m_write_req), 64'h1);
        chk({tag, "_mwaddr"}, 64'(cb.m_waddr), 64'(e.addr));
        @(negedge ACLK);
        chk({tag, "_mwreq_once"}, 64'(cb.m_write_req), 64'h0);
        cb.m_bresp      = e.resp;
        cb.m_write_done = 1'b1;
        @(negedge ACLK);
        cb.m_write_done = 1'b0;
        cb.m_bresp      = 2'b00;
        wait_wr_done(tag);
    endtask

    task automatic rd_complete(input string tag, input bit drop);
        exp_t e;
        e = rd_sb[0];
        @(negedge ACLK);
        if (drop) rb.rd_req = '0;
        chk({tag, "_mrreq"}, 64'(cb.m_read_req), 64'h1);
        chk({tag, "_mraddr"}, 64'(cb.m_raddr), 64'(e.addr));
        @(negedge ACLK);
        chk({tag, "_mrreq_once"}, 64'(cb.m_read_req), 64'h0);
        cb.m_rresp     = e.resp;
        cb.m_rdata     = e.data;
        cb.m_read_done = 1'b1;
        @(negedge ACLK);
        cb.m_read_done = 1'b0;
        cb.m_rresp     = 2'b00;
        cb.m_rdata     = '0;
        wait_rd_done(tag);
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_order [5];
        int rd_order [3];
        wr_order = '{0, 1, 2, 3, 0};
`ifdef ARB_FIXED_PRIO_EN
        rd_order = '{1, 1, 1};
`else
        rd_order = '{1, 3, 1};
`endif
        rb.wr_req = '0; rb.wr_addr = '0; rb.wr_data = '0; rb.wr_strb = '0;
        rb.rd_req = '0; rb.rd_addr = '0;
        cb.m_write_done = 1'b0; cb.m_read_done = 1'b0;
        cb.m_bresp = 2'b00; cb.m_rresp = 2'b00; cb.m_rdata = '0;
        for (int i = 0; i < N; i++) rb.rd_addr[i*AW +: AW] = 32'h100 + 32'(i * 4);

        // Reset state, with a request pending that must not be granted
        repeat (2) @(negedge ACLK);
        rb.wr_req = 4'b0001;
        #1;
        chk("rst_wgnt", 64'(rb.wr_gnt), 64'h0);
        chk("rst_mwaddr", 64'(cb.m_waddr), 64'h0);
        chk("rst_mwstrb", 64'(cb.m_wstrb), 64'h0);
        chk("rst_mwreq", 64'(cb.m_write_req), 64'h0);
        chk("rst_wdone", 64'(rb.wr_done), 64'h0);
        chk("rst_rdata", 64'(rb.rd_data), 64'h0);
        rb.wr_req = '0;
        ARESETn = 1'b1;
        repeat (4) @(negedge ACLK);

        // 1: single write from requester 0
        set_wr(0, 32'h10, 32'hDEADBEEF, 4'hF);
        rb.wr_req = 4'b0001;
        #1;
        wr_expect_grant("t1", 0, RESP_OKAY);
        wr_complete("t1", 1'b1);
        chk("t1_wdata_held", 64'(cb.m_wdata), 64'hDEADBEEF);
        chk("t1_wstrb_held", 64'(cb.m_wstrb), 64'hF);
        @(negedge ACLK);
        chk("t1_wdone_pulse", 64'(rb.wr_done), 64'h0);
        chk("t1_bresp_held", 64'(rb.wr_bresp), 64'(RESP_OKAY));

        // 3: concurrent read (req 2) and write (req 1)
        set_wr(1, 32'h20, 32'h11112222, 4'h3);
        rb.rd_addr[2*AW +: AW] = 32'h40;
        rb.wr_req = 4'b0010;
        rb.rd_req = 4'b0100;
        #1;
        wr_expect_grant("t3", 1, RESP_OKAY);
        rd_expect_grant("t3", 2, RESP_OKAY, 32'hCAFEF00D);
        @(negedge ACLK);
        rb.wr_req = '0;
        rb.rd_req = '0;
        chk("t3_mwreq", 64'(cb.m_write_req), 64'h1);
        chk("t3_mrreq", 64'(cb.m_read_req), 64'h1);
        chk("t3_mraddr", 64'(cb.m_raddr), 64'h40);
        @(negedge ACLK);
        cb.m_rdata = 32'hCAFEF00D;
        cb.m_rresp = RESP_OKAY;
        cb.m_read_done = 1'b1;
        @(negedge ACLK);
        cb.m_read_done = 1'b0;
        wait_rd_done("t3");
        chk("t3_wdone_idle", 64'(rb.wr_done), 64'h0);
        cb.m_bresp = RESP_OKAY;
        cb.m_write_done = 1'b1;
        @(negedge ACLK);
        cb.m_write_done = 1'b0;
        wait_wr_done("t3");

        // Stray completions in ARB_IDLE are ignored
        @(negedge ACLK);
        cb.m_write_done = 1'b1;
        cb.m_read_done  = 1'b1;
        cb.m_bresp      = RESP_DECERR;
        @(negedge ACLK);
        cb.m_write_done = 1'b0;
        cb.m_read_done  = 1'b0;
        cb.m_bresp      = RESP_OKAY;
        chk("stray_wdone", 64'(rb.wr_done), 64'h0);
        chk("stray_rdone", 64'(rb.rd_done), 64'h0);
        chk("stray_bresp_held", 64'(rb.wr_bresp), 64'(RESP_OKAY));

        // 4: startup hold-off after reset release
        do_reset();
        set_wr(3, 32'h30, 32'h33334444, 4'hC);
        @(negedge ACLK);
        rb.wr_req = 4'b1000;
        #1;
        chk("t4_hold1", 64'(rb.wr_gnt), 64'h0);
        @(negedge ACLK);
        #1;
        chk("t4_hold2", 64'(rb.wr_gnt), 64'h0);
        @(negedge ACLK);
        #1;
        wr_expect_grant("t4", 3, RESP_OKAY);
        wr_complete("t4", 1'b1);

        // 5: reset while waiting on the master abandons the transfer
        set_wr(1, 32'h50, 32'h55556666, 4'h1);
        @(negedge ACLK);
        rb.wr_req = 4'b0010;
        #1;
        chk("t5_wgnt", 64'(rb.wr_gnt), 64'h2);
        @(negedge ACLK);
        rb.wr_req = '0;
        @(negedge ACLK);
        ARESETn = 1'b0;
        @(negedge ACLK);
        chk("t5_mwaddr", 64'(cb.m_waddr), 64'h0);
        chk("t5_mwdata", 64'(cb.m_wdata), 64'h0);
        chk("t5_mwstrb", 64'(cb.m_wstrb), 64'h0);
        chk("t5_mwreq", 64'(cb.m_write_req), 64'h0);
        cb.m_write_done = 1'b1;
        @(negedge ACLK);
        cb.m_write_done = 1'b0;
        ARESETn = 1'b1;
        chk("t5_no_wdone", 64'(rb.wr_done), 64'h0);
        for (int i = 0; i < N; i++) set_wr(i, 32'h200 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
        rb.wr_req = 4'b1111;
        repeat (3) @(negedge ACLK);
        #1;

        // 2: all requesters held, round-robin order from a reset pointer
        for (int k = 0; k < 5; k++) begin
            wr_expect_grant($sformatf("t2_%0d", k), wr_order[k], RESP_OKAY);
            wr_complete($sformatf("t2_%0d", k), k == 4);
            #1;
        end

        // Slave error response reaches the requester and is held
        set_wr(2, 32'h60, 32'h77778888, 4'h8);
        @(negedge ACLK);
        rb.wr_req = 4'b0100;
        #1;
        wr_expect_grant("slverr", 2, RESP_SLVERR);
        wr_complete("slverr", 1'b1);
        @(negedge ACLK);
        chk("slverr_held", 64'(rb.wr_bresp), 64'(RESP_SLVERR));

        // 6: rd_req=1010 held; order depends on arbitration mode
        @(negedge ACLK);
        rb.rd_req = 4'b1010;
        #1;
        for (int k = 0; k < 3; k++) begin
            rd_expect_grant($sformatf("t6_%0d", k), rd_order[k],
                            (k == 1) ? RESP_EXOKAY : RESP_SLVERR, 32'h9000_0000 + 32'(k));
            rd_complete($sformatf("t6_%0d", k), k == 2);
            #1;
        end
        chk("wr_sb_drained", 64'(wr_sb.size()), 64'h0);
        chk("rd_sb_drained", 64'(rd_sb.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
